// File: rtl/core_mem_bridge_pkg.sv
// core_mem_bridge_pkg
//   Shared widths and FSM state type for the core-to-bus memory bridge.
//   Imported by mem_req_slot and core_mem_bridge.
package core_mem_bridge_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_D_REQ,
        ST_D_WAIT,
        ST_I_REQ,
        ST_I_WAIT,
        ST_DONE
    } state_t;

    // A bus access is outstanding in these states; the pipeline must hold.
    function automatic logic is_busy(input state_t s);
        return (s == ST_D_REQ) || (s == ST_D_WAIT) ||
               (s == ST_I_REQ) || (s == ST_I_WAIT);
    endfunction

endpackage

// File: rtl/core_mem_bridge_mem_req_slot.sv
// mem_req_slot
//   Holds one latched core request (pending flag, addr, wdata, byte strobes)
//   and the registered read data returned for it.
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   capture               latch capture_* fields and mark the request pending
//   capture_addr/wdata/wen request fields from the core port
//   complete              this slot owns the bus response phase (its *_WAIT)
//   data_ok, bus_rdata    bus response; rdata is loaded only for reads
//   pending, addr, wdata, wen   latched request
//   rdata                 registered read data, changes only on a completed read
module mem_req_slot
    import core_mem_bridge_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              capture,
    input  logic [ADDR_W-1:0] capture_addr,
    input  logic [DATA_W-1:0] capture_wdata,
    input  logic [STRB_W-1:0] capture_wen,
    input  logic              complete,
    input  logic              data_ok,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              pending,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    output logic [STRB_W-1:0] wen,
    output logic [DATA_W-1:0] rdata
);

    logic              pending_q, pending_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [DATA_W-1:0] wdata_q,   wdata_d;
    logic [STRB_W-1:0] wen_q,     wen_d;
    logic [DATA_W-1:0] rdata_q,   rdata_d;

    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
        pending_d = pending_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wen_d     = wen_q;
        rdata_d   = rdata_q;
        if (capture) begin
            pending_d = 1'b1;
            addr_d    = capture_addr;
            wdata_d   = capture_wdata;
            wen_d     = capture_wen;
        end
        if (complete && data_ok) begin
            pending_d = 1'b0;
            if (wen_q == '0) begin
                rdata_d = bus_rdata;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wen_q     <= '0;
            rdata_q   <= '0;
        end else begin
            pending_q <= pending_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wen_q     <= wen_d;
            rdata_q   <= rdata_d;
        end
    end

    assign pending = pending_q;
    assign addr    = addr_q;
    assign wdata   = wdata_q;
    assign wen     = wen_q;
    assign rdata   = rdata_q;

endmodule

// File: rtl/core_mem_bridge.sv
// core_mem_bridge
//   Serialises the core's instruction and data SRAM-style ports onto one
//   variable-latency bus (req/addr_ok/data_ok). Data access goes first.
//   stallreq_for_bus holds the pipeline until every request of the cycle is
//   done; rdata registers give the pipeline a synchronous-SRAM view.
// Ports:
//   clk, rst                     clock, asynchronous active-low reset
//   inst_sram_*                  fetch port (wen/wdata ignored, read-only)
//   data_sram_*                  load/store port (wen==0 means load)
//   stallreq_for_bus             pipeline hold request to CTRL
//   bus_req/wr/wstrb/addr/wdata  bus request channel
//   bus_addr_ok/data_ok/rdata    bus accept and response
module core_mem_bridge
    import core_mem_bridge_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_sram_en,
    input  logic [3:0]  inst_sram_wen,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        stallreq_for_bus,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata
);

    state_t state_q, state_d;

    logic              cap_data, cap_inst;
    logic              data_pending, inst_pending;
    logic [ADDR_W-1:0] data_addr, inst_addr;
    logic [DATA_W-1:0] data_wdata, inst_wdata;
    logic [STRB_W-1:0] data_wen, inst_wen;

    // Fetch is read-only: the inst slot is always captured with zero strobes.
    logic unused_ok;
    assign unused_ok = ^{inst_sram_wen, inst_sram_wdata, data_pending};

    mem_req_slot u_data_slot (
        .clk           (clk),
        .rst           (rst),
        .capture       (cap_data),
        .capture_addr  (data_sram_addr),
        .capture_wdata (data_sram_wdata),
        .capture_wen   (data_sram_wen),
        .complete      (state_q == ST_D_WAIT),
        .data_ok       (bus_data_ok),
        .bus_rdata     (bus_rdata),
        .pending       (data_pending),
        .addr          (data_addr),
        .wdata         (data_wdata),
        .wen           (data_wen),
        .rdata         (data_sram_rdata)
    );

    mem_req_slot u_inst_slot (
        .clk           (clk),
        .rst           (rst),
        .capture       (cap_inst),
        .capture_addr  (inst_sram_addr),
        .capture_wdata ('0),
        .capture_wen   ('0),
        .complete      (state_q == ST_I_WAIT),
        .data_ok       (bus_data_ok),
        .bus_rdata     (bus_rdata),
        .pending       (inst_pending),
        .addr          (inst_addr),
        .wdata         (inst_wdata),
        .wen           (inst_wen),
        .rdata         (inst_sram_rdata)
    );

    always_comb begin
        state_d   = state_q;
        cap_data  = 1'b0;
        cap_inst  = 1'b0;
        bus_req   = 1'b0;
        bus_wr    = 1'b0;
        bus_wstrb = '0;
        bus_addr  = '0;
        bus_wdata = '0;
        case (state_q)
            ST_IDLE: begin
                if (data_sram_en) begin
                    cap_data = 1'b1;
                    cap_inst = inst_sram_en;
                    state_d  = ST_D_REQ;
                end else if (inst_sram_en) begin
                    cap_inst = 1'b1;
                    state_d  = ST_I_REQ;
                end
            end
            ST_D_REQ: begin
                bus_req   = 1'b1;
                bus_wr    = |data_wen;
                bus_wstrb = data_wen;
                bus_addr  = data_addr;
                bus_wdata = data_wdata;
                if (bus_addr_ok) state_d = ST_D_WAIT;
            end
            ST_D_WAIT: begin
                if (bus_data_ok) state_d = inst_pending ? ST_I_REQ : ST_DONE;
            end
            ST_I_REQ: begin
                bus_req   = 1'b1;
                bus_wr    = |inst_wen;
                bus_wstrb = inst_wen;
                bus_addr  = inst_addr;
                bus_wdata = inst_wdata;
                if (bus_addr_ok) state_d = ST_I_WAIT;
            end
            ST_I_WAIT: begin
                if (bus_data_ok) state_d = ST_DONE;
            end
            // The core still presents the request just served; do not re-latch it.
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Combinational in IDLE so the pipeline freezes in the cycle it asks;
    // forced low while reset is asserted.
    assign stallreq_for_bus = rst &
        (((state_q == ST_IDLE) & (inst_sram_en | data_sram_en)) | is_busy(state_q));

endmodule
